fft_input_buffer: RTL
=====================

Name: fft_input_buffer

Overview:
Receive-side frame buffer in front of the FFT core.
- Accepts a full frame of SAMPLES fixed-point samples as wide INPUT_SIZE-bit host lines, one line per handshake.
- Unpacks and stores the frame, then streams the samples one per handshake to the FFT core.
- Mirror of the output-side collector: line-wide in, sample-wide out.

Parameters:
SIZE, 16, bits per sample
SAMPLES, 2048, samples per frame (power of two)
INPUT_SIZE, 512, bits per host line; SAMPLES*SIZE divisible by INPUT_SIZE

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
line_valid  in  1  host line present on line_data
line_ready  out  1  block accepts a line this cycle
line_data  in  INPUT_SIZE  host line; sample k of the line = line_data[SIZE*k +: SIZE]
sample_valid  out  1  sample_data/sample_index valid
sample_ready  in  1  FFT core accepts the sample
sample_data  out  SIZE  streamed sample
sample_index  out  $clog2(SAMPLES)  stream position 0..SAMPLES-1
frame_last  out  1  high with sample_valid when sample_index == SAMPLES-1
frame_done  out  1  one-cycle pulse after the last sample transfers

Behaviour:
- Derived constants: SAMPLES_PER_LINE = INPUT_SIZE/SIZE (32); LINES_PER_FRAME = SAMPLES*SIZE/INPUT_SIZE (64).
- Storage: buffer[SAMPLES] of SIZE bits. Line L, slot k is written to buffer[L*SAMPLES_PER_LINE + k].
- Reset (async, rst=1):
  - state=IDLE; line counter=0; stream counter=0.
  - line_ready=0, sample_valid=0, frame_last=0, frame_done=0, sample_index=0.
  - Buffer contents are not cleared.
- FSM transitions:
  - IDLE -> FILL unconditionally on the first clock after rst deasserts.
  - FILL: line_ready=1 and sample_valid=0. A line transfers when line_valid && line_ready; it is written and the line counter increments. The transfer of line LINES_PER_FRAME-1 moves the FSM to STREAM on the same edge and zeroes the line counter.
  - STREAM: line_ready=0, and line_valid is ignored. sample_valid=1 starting in the cycle after the last line transfer. sample_data = buffer[rd_addr] combinationally, where rd_addr = stream counter. A sample transfers when sample_valid && sample_ready, and the stream counter increments. The transfer at counter SAMPLES-1 moves the FSM to FILL, zeroes the stream counter and pulses frame_done for one cycle in the following cycle.
- Latency:
  - Minimum 1 cycle from the last line transfer to the first sample_valid.
  - In the cycle frame_done is high, line_ready is already 1.
- Backpressure: while sample_ready=0, sample_data, sample_index and frame_last hold stable.
- Counters: line counter is $clog2(LINES_PER_FRAME) bits; stream counter is $clog2(SAMPLES) bits. Neither wraps except through the FSM transitions above.
- Reset mid-FILL or mid-STREAM: frame is discarded, all counters zero, and the FSM restarts at IDLE. Partial buffer data is not streamed.
- sample_index always equals the stream counter.

Optional Feature:
Macro: FFT_INPUT_BIT_REVERSE_EN.
- Defined: rd_addr = bit-reverse of the stream counter over $clog2(SAMPLES) bits, producing decimation-in-time input order for the radix-2 core. sample_index still reports sequential position.
- Undefined: rd_addr = stream counter (natural order). No bit-reverse logic is instantiated.

Decomposition:
- Shared package fft_io_pkg holds:
  - SIZE, SAMPLES, INPUT_SIZE defaults
  - derived SAMPLES_PER_LINE, LINES_PER_FRAME
  - sample_t typedef (logic [SIZE-1:0])
  - state enum {IDLE, FILL, STREAM}
- One sub-module: fft_bit_reverse, a parameterised-width combinational address reverser. It is instantiated only under FFT_INPUT_BIT_REVERSE_EN and is reusable by the output side.

Test Plan:
- Fill order: release reset, then drive 64 lines with sample_ready=1 and every slot k of line L = L*32+k. Required:
  - sample_valid rises 1 cycle after the 64th line transfer.
  - 2048 consecutive samples with sample_data == sample_index == 0..2047.
  - frame_last only at index 2047; frame_done pulses once.
- Backpressure: toggle sample_ready randomly (≈50%). Required: no dropped or duplicated samples, and outputs held stable while ready=0.
- Host stall and ignore: insert line_valid gaps during FILL, and hold line_valid=1 with garbage line_data during STREAM. Required: garbage is never written, and streamed data matches the first test.
- Back-to-back frames: second frame uses value L*32+k+0x100, with line_valid held high across frame_done. Required: line_ready=1 in the frame_done cycle, and frame 2 streams 0x100..0x8FF.
- Reset mid-operation: assert rst after 10 lines, and again after 500 streamed samples. Required: outputs return to reset values immediately, and the next full fill streams correctly from index 0.
- With FFT_INPUT_BIT_REVERSE_EN defined and the first test's fill: index 0 -> 0, 1 -> 1024, 2 -> 512, 3 -> 1536, 2047 -> 2047.

Source files
------------

// File: rtl/fft_io_pkg.sv
// -----------------------------------------------------------------------------
// fft_io_pkg
// Shared definitions for the FFT host-side I/O blocks (input buffer and
// output collector): default frame geometry, derived line/frame constants,
// the sample type and the buffer FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package fft_io_pkg;

    localparam int unsigned SIZE             = 16;
    localparam int unsigned SAMPLES          = 2048;
    localparam int unsigned INPUT_SIZE       = 512;

    localparam int unsigned SAMPLES_PER_LINE = INPUT_SIZE / SIZE;
    localparam int unsigned LINES_PER_FRAME  = (SAMPLES * SIZE) / INPUT_SIZE;

    typedef logic [SIZE-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_e;

endpackage

// File: rtl/fft_bit_reverse.sv
// -----------------------------------------------------------------------------
// fft_bit_reverse
// Combinational address bit reverser (bit i of the result = bit WIDTH-1-i of
// the input). Used to turn a sequential counter into radix-2 DIT order.
// Ports:
//   addr        in   WIDTH  natural-order address
//   addr_rev_c  out  WIDTH  bit-reversed address (combinational)
// -----------------------------------------------------------------------------
module fft_bit_reverse #(
    parameter int unsigned WIDTH = 11
) (
    input  logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] addr_rev_c
);

    always_comb begin
        addr_rev_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            addr_rev_c[i] = addr[WIDTH-1-i];
        end
    end

endmodule

// File: rtl/fft_input_buffer.sv
// -----------------------------------------------------------------------------
// fft_input_buffer
// Receive-side frame buffer in front of the FFT core. Collects one frame of
// SAMPLES samples delivered as INPUT_SIZE-bit host lines, then streams the
// samples one per handshake to the core.
// Optional build macro: FFT_INPUT_BIT_REVERSE_EN -- read the buffer in
// bit-reversed address order (DIT input order); sample_index stays sequential.
// Ports:
//   clk           in   1           clock, rising edge
//   rst           in   1           asynchronous active-high reset
//   line_valid    in   1           host line present
//   line_ready    out  1           line accepted this cycle (FILL)
//   line_data     in   INPUT_SIZE  host line, slot k = [SIZE*k +: SIZE]
//   sample_valid  out  1           sample_data/sample_index valid (STREAM)
//   sample_ready  in   1           FFT core accepts the sample
//   sample_data   out  SIZE        streamed sample (combinational buffer read)
//   sample_index  out  log2(SAMPLES) stream position
//   frame_last    out  1           high with sample_valid at the final index
//   frame_done    out  1           one-cycle pulse after the final transfer
// -----------------------------------------------------------------------------
module fft_input_buffer #(
    parameter int unsigned SIZE       = fft_io_pkg::SIZE,
    parameter int unsigned SAMPLES    = fft_io_pkg::SAMPLES,
    parameter int unsigned INPUT_SIZE = fft_io_pkg::INPUT_SIZE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       line_valid,
    output logic                       line_ready,
    input  logic [INPUT_SIZE-1:0]      line_data,
    output logic                       sample_valid,
    input  logic                       sample_ready,
    output logic [SIZE-1:0]            sample_data,
    output logic [$clog2(SAMPLES)-1:0] sample_index,
    output logic                       frame_last,
    output logic                       frame_done
);

    import fft_io_pkg::*;

    localparam int unsigned SAMPLES_PER_LINE = INPUT_SIZE / SIZE;
    localparam int unsigned LINES_PER_FRAME  = (SAMPLES * SIZE) / INPUT_SIZE;
    localparam int unsigned ADDR_W           = $clog2(SAMPLES);
    localparam int unsigned LINE_W           = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;

    localparam logic [LINE_W-1:0] LAST_LINE   = LINE_W'(LINES_PER_FRAME - 1);
    localparam logic [ADDR_W-1:0] LAST_SAMPLE = ADDR_W'(SAMPLES - 1);

    state_e              state_q;
    state_e              state_d;
    logic [LINE_W-1:0]   line_cnt_q;
    logic [LINE_W-1:0]   line_cnt_d;
    logic [ADDR_W-1:0]   strm_cnt_q;
    logic [ADDR_W-1:0]   strm_cnt_d;
    logic                frame_done_d;
    logic                line_wr_c;
    logic [ADDR_W-1:0]   wr_base_c;
    logic [ADDR_W-1:0]   rd_addr_c;

    logic [SIZE-1:0]     buffer [SAMPLES];

    // Next-state / counter logic
    always_comb begin
        state_d      = state_q;
        line_cnt_d   = line_cnt_q;
        strm_cnt_d   = strm_cnt_q;
        frame_done_d = 1'b0;
        line_wr_c    = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FILL;
            end

            FILL: begin
                if (line_valid && line_ready) begin
                    line_wr_c = 1'b1;
                    if (line_cnt_q == LAST_LINE) begin
                        line_cnt_d = '0;
                        state_d    = STREAM;
                    end else begin
                        line_cnt_d = line_cnt_q + LINE_W'(1);
                    end
                end
            end

            STREAM: begin
                if (sample_valid && sample_ready) begin
                    if (strm_cnt_q == LAST_SAMPLE) begin
                        strm_cnt_d   = '0;
                        state_d      = FILL;
                        frame_done_d = 1'b1;
                    end else begin
                        strm_cnt_d = strm_cnt_q + ADDR_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered handshake/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            line_cnt_q   <= '0;
            strm_cnt_q   <= '0;
            line_ready   <= 1'b0;
            sample_valid <= 1'b0;
            frame_last   <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_cnt_q   <= line_cnt_d;
            strm_cnt_q   <= strm_cnt_d;
            line_ready   <= (state_d == FILL);
            sample_valid <= (state_d == STREAM);
            frame_last   <= (state_d == STREAM) && (strm_cnt_d == LAST_SAMPLE);
            frame_done   <= frame_done_d;
        end
    end

    assign sample_index = strm_cnt_q;

    // First buffer slot of the line currently being written
    assign wr_base_c = ADDR_W'(ADDR_W'(line_cnt_q) * ADDR_W'(SAMPLES_PER_LINE));

    // Sample storage; contents survive reset by design
    always_ff @(posedge clk) begin
        if (line_wr_c) begin
            for (int unsigned k = 0; k < SAMPLES_PER_LINE; k++) begin
                buffer[wr_base_c + ADDR_W'(k)] <= line_data[SIZE*k +: SIZE];
            end
        end
    end

`ifdef FFT_INPUT_BIT_REVERSE_EN
    fft_bit_reverse #(
        .WIDTH (ADDR_W)
    ) u_rd_rev (
        .addr       (strm_cnt_q),
        .addr_rev_c (rd_addr_c)
    );
`else
    assign rd_addr_c = strm_cnt_q;
`endif

    assign sample_data = buffer[rd_addr_c];

endmodule
